axi_slave_mem: RTL
==================

// Module: axi_slave_mem
// PURPOSE: AXI4 memory-mapped responder with an internal word-addressed RAM. Accepts INCR/FIXED write and read bursts from the AXI4 master.
//   Serves as the far end of the master's AW/W/B/AR/R channels in system and bench. Write and read paths are independent FSMs sharing one RAM.
// PARAMETERS
//   ADDR_WIDTH  32   byte-address width of awaddr/araddr
//   DATA_WIDTH  32   data bus width in bits (multiple of 8); one beat = one RAM word
//   ID_WIDTH    4    transaction ID width; bid/rid echo awid/arid
//   MEM_DEPTH   256  RAM depth in words (power of two); valid bytes 0 .. MEM_DEPTH*DATA_WIDTH/8-1
// PORTS
//   clk      in   1             clock, rising edge
//   rst      in   1             reset, asynchronous, active-high
//   awid     in   ID_WIDTH      write ID
//   awaddr   in   ADDR_WIDTH    write start byte address
//   awlen    in   8             write beats minus 1
//   awsize   in   3             beat size (ignored; full-width beats)
//   awburst  in   2             00 FIXED, 01 INCR, 10/11 unsupported
//   awvalid  in   1             AW valid
//   awready  out  1             AW ready
//   wdata    in   DATA_WIDTH    write data
//   wstrb    in   DATA_WIDTH/8  byte enables
//   wlast    in   1             last write beat
//   wvalid   in   1             W valid
//   wready   out  1             W ready
//   bid      out  ID_WIDTH      response ID = latched awid
//   bresp    out  2             00 OKAY, 10 SLVERR
//   bvalid   out  1             B valid
//   bready   in   1             B ready
//   arid     in   ID_WIDTH      read ID
//   araddr   in   ADDR_WIDTH    read start byte address
//   arlen    in   8             read beats minus 1
//   arsize   in   3             beat size (ignored)
//   arburst  in   2             as awburst
//   arvalid  in   1             AR valid
//   arready  out  1             AR ready
//   rid      out  ID_WIDTH      = latched arid
//   rdata    out  DATA_WIDTH    read data
//   rresp    out  2             00 OKAY, 10 SLVERR
//   rlast    out  1             last read beat
//   rvalid   out  1             R valid
//   rready   in   1             R ready
// BEHAVIOUR
//   Reset: awready=1, arready=1, wready=0, bvalid=0, bresp=0, bid=0, rvalid=0, rlast=0, rdata=0, rresp=0, rid=0; RAM contents NOT cleared. Reset mid-burst abandons it; no B/R issued.
//   Word index = addr >> log2(DATA_WIDTH/8); low address bits ignored. Each beat advances index by 1 (INCR) or 0 (FIXED).
//   Error: start index >= MEM_DEPTH, INCR burst with start+len >= MEM_DEPTH, or burst 10/11 -> SLVERR for whole burst, no RAM writes, rdata=0 on all beats.
//   Write FSM W_IDLE->W_DATA->W_RESP. W_IDLE: awready=1; on AW handshake latch id/index/len/burst/err, awready<=0, wready<=1.
//   W_DATA: per W handshake write bytes where wstrb=1 (unless err), beat count++. Beat count==awlen ends burst: wready<=0, bvalid<=1; wlast on wrong beat -> bresp SLVERR (data still written).
//   W_RESP: bvalid/bresp/bid held until bready; on handshake bvalid<=0, awready<=1, -> W_IDLE. Earliest bvalid: cycle after last W handshake.
//   Read FSM R_IDLE->R_DATA. R_IDLE: arready=1; on AR handshake latch, arready<=0; next cycle rvalid=1 with beat 0 (rlast=(arlen==0)).
//   R_DATA: rdata/rresp/rlast/rid stable while rvalid&&!rready; on handshake next beat presented next cycle (no bubbles); handshake with rlast -> rvalid<=0, rlast<=0, arready<=1, R_IDLE.
//   Same-cycle read and write to one word: read returns pre-write data. AW and AR may be accepted in the same cycle; one outstanding burst per direction.
// TESTING
//   INCR write awaddr=0x10 awlen=3 data A0..A3 wstrb=F -> bresp=00 bid=awid; read same -> rdata A0..A3, rlast on beat 3 only, rresp=00.
//   Preload 0x11223344 at 0x40, write 0xFFFFFFFF wstrb=0101 -> readback 0x11FF33FF.
//   FIXED write 0x20 awlen=2 data 1,2,3 -> word 0x20 reads 3, 0x24 unchanged.
//   araddr=0x400 arlen=1 (depth 256) -> 2 beats rresp=10 rdata=0; awaddr=0x3FC awlen=1 -> bresp=10, 0x3FC unchanged.
//   Random rready/bready stalls -> no beat lost/duplicated, outputs stable while stalled; rst at write beat 2 -> outputs to reset values immediately, beats 0-1 retained.

Source files
------------

// File: rtl/axi_slave_mem.sv
// AXI4 responder backed by a word-addressed RAM; independent write (AW/W/B) and read (AR/R) FSMs.
// R beat 0 follows the AR handshake by one cycle, then one beat per rready cycle; B follows the last W beat by one cycle.
module axi_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;

  // Out of range start, an INCR burst running past the top, or a reserved burst type.
  function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [7:0] len,
                                     input logic [1:0] burst);
    logic [ADDR_WIDTH:0] first;
    logic [ADDR_WIDTH:0] final_idx;
    first     = (ADDR_WIDTH+1)'(addr >> OFF);
    final_idx = first + (ADDR_WIDTH+1)'(len);
    burst_err = burst[1]
             || (first >= (ADDR_WIDTH+1)'(MEM_DEPTH))
             || ((burst == 2'b01) && (final_idx >= (ADDR_WIDTH+1)'(MEM_DEPTH)));
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t       w_state;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]     w_len;
  logic [7:0]     w_cnt;
  logic           w_fixed;
  logic           w_err;
  logic           w_last_err;
  logic           w_we;

  r_state_t       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_nidx;
  logic [7:0]     r_len;
  logic [7:0]     r_cnt;
  logic           r_fixed;
  logic           r_err;

  logic [IDX_W-1:0] aw_idx;
  logic [IDX_W-1:0] ar_idx;
  logic           aw_err;
  logic           ar_err;
  logic           unused_size;

  assign aw_idx      = IDX_W'(awaddr >> OFF);
  assign ar_idx      = IDX_W'(araddr >> OFF);
  assign aw_err      = burst_err(awaddr, awlen, awburst);
  assign ar_err      = burst_err(araddr, arlen, arburst);
  assign unused_size = ^{awsize, arsize};

  assign w_we   = (w_state == W_DATA) && wvalid && wready && !w_err;
  assign r_nidx = r_fixed ? r_idx : r_idx + IDX_W'(1);

  // RAM is deliberately left out of reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state    <= W_IDLE;
      awready    <= 1'b1;
      wready     <= 1'b0;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
      bid        <= '0;
      w_idx      <= '0;
      w_len      <= '0;
      w_cnt      <= '0;
      w_fixed    <= 1'b0;
      w_err      <= 1'b0;
      w_last_err <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            bid        <= awid;
            w_idx      <= aw_idx;
            w_len      <= awlen;
            w_fixed    <= (awburst == 2'b00);
            w_err      <= aw_err;
            w_cnt      <= '0;
            w_last_err <= 1'b0;
            awready    <= 1'b0;
            wready     <= 1'b1;
            w_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            if (!w_fixed) w_idx <= w_idx + IDX_W'(1);
            w_cnt <= w_cnt + 8'd1;
            // Burst length comes from awlen; a misplaced wlast only taints the response.
            if (w_cnt == w_len) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (w_err || w_last_err || !wlast) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else if (wlast) begin
              w_last_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: begin
          w_state <= W_IDLE;
          awready <= 1'b1;
          wready  <= 1'b0;
          bvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Reads sample the RAM before this cycle's write lands, giving pre-write data on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fixed <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            rid     <= arid;
            r_idx   <= ar_idx;
            r_len   <= arlen;
            r_fixed <= (arburst == 2'b00);
            r_err   <= ar_err;
            r_cnt   <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rlast   <= (arlen == 8'd0);
            rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
            rdata   <= ar_err ? '0 : mem[ar_idx];
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_idx <= r_nidx;
              r_cnt <= r_cnt + 8'd1;
              rlast <= ((r_cnt + 8'd1) == r_len);
              rdata <= r_err ? '0 : mem[r_nidx];
            end
          end
        end
        default: begin
          r_state <= R_IDLE;
          arready <= 1'b1;
          rvalid  <= 1'b0;
          rlast   <= 1'b0;
        end
      endcase
    end
  end

endmodule
